// File: rtl/clock_control.sv
// rtl/clock_control.sv - CPU clock source: auto free-run or debounced manual single-step, with halt.
module clock_control #(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int STEP_HIGH_CYCLES = 2500000,
    parameter int CNT_W            = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_cpu_in,
    input  logic btn_step,
    input  logic sw_mode,
    input  logic hlt,
    output logic clk_out,
    output logic clk_rise,
    output logic clk_fall,
    output logic halted,
    output logic mode_manual
);

    typedef enum logic [1:0] {
        S_AUTO      = 2'd0,
        S_MAN_IDLE  = 2'd1,
        S_MAN_PULSE = 2'd2,
        S_HALT      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_HIGH_CYCLES - 1);

    // Bit 0 is the step button, bit 1 the mode switch.
    logic [1:0]            s1_q, s1_d;
    logic [1:0]            s2_q, s2_d;
    logic [1:0]            db_q, db_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                  btn_prev_q, btn_prev_d;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      step_cnt_q, step_cnt_d;
    logic                  clk_out_q, clk_out_d;
    logic                  clk_out_dly_q, clk_out_dly_d;

    logic                  press_evt;
    logic                  mode_db;

    always_comb begin
        s1_d       = {sw_mode, btn_step};
        s2_d       = s1_q;
        db_d       = db_q;
        cnt_d      = '0;
        btn_prev_d = db_q[0];
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press_evt = db_q[0] & ~btn_prev_q;
    assign mode_db   = db_q[1];

    always_comb begin
        state_d       = state_q;
        step_cnt_d    = step_cnt_q;
        clk_out_d     = 1'b0;
        clk_out_dly_d = clk_out_q;
        case (state_q)
            S_AUTO: begin
                clk_out_d = clk_cpu_in;
                // Leave only from a low phase so a high phase is never cut short.
                if (!clk_cpu_in) begin
                    if (hlt) begin
                        state_d = S_HALT;
                    end else if (mode_db) begin
                        state_d = S_MAN_IDLE;
                    end
                end
            end
            S_MAN_IDLE: begin
                if (hlt) begin
                    state_d = S_HALT;
                end else if (!mode_db) begin
                    state_d = S_AUTO;
                end else if (press_evt) begin
                    state_d    = S_MAN_PULSE;
                    step_cnt_d = STEP_LAST;
                    clk_out_d  = 1'b1;
                end
            end
            S_MAN_PULSE: begin
                if (step_cnt_q == '0) begin
                    state_d = S_MAN_IDLE;
                end else begin
                    step_cnt_d = step_cnt_q - CNT_W'(1);
                    clk_out_d  = 1'b1;
                end
            end
            S_HALT: begin
                if (!hlt) begin
                    state_d = mode_db ? S_MAN_IDLE : S_AUTO;
                end
            end
            default: state_d = S_AUTO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q          <= '0;
            s2_q          <= '0;
            db_q          <= '0;
            cnt_q         <= '0;
            btn_prev_q    <= 1'b0;
            state_q       <= S_AUTO;
            step_cnt_q    <= '0;
            clk_out_q     <= 1'b0;
            clk_out_dly_q <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            db_q          <= db_d;
            cnt_q         <= cnt_d;
            btn_prev_q    <= btn_prev_d;
            state_q       <= state_d;
            step_cnt_q    <= step_cnt_d;
            clk_out_q     <= clk_out_d;
            clk_out_dly_q <= clk_out_dly_d;
        end
    end

    assign clk_out     = clk_out_q;
    assign clk_rise    = clk_out_q & ~clk_out_dly_q;
    assign clk_fall    = ~clk_out_q & clk_out_dly_q;
    assign halted      = (state_q == S_HALT);
    assign mode_manual = (state_q == S_MAN_IDLE) || (state_q == S_MAN_PULSE);

endmodule

// File: tb/tb_clock_control.sv
// tb/tb_clock_control.sv - directed scoreboard bench for clock_control.
module tb_clock_control;

    localparam int DB = 4;
    localparam int SH = 3;

    logic clk = 1'b0;
    logic reset, clk_cpu_in, btn_step, sw_mode, hlt;
    logic clk_out, clk_rise, clk_fall, halted, mode_manual;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    clock_control #(
        .DEBOUNCE_CYCLES (DB),
        .STEP_HIGH_CYCLES(SH),
        .CNT_W           (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_cpu_in (clk_cpu_in),
        .btn_step   (btn_step),
        .sw_mode    (sw_mode),
        .hlt        (hlt),
        .clk_out    (clk_out),
        .clk_rise   (clk_rise),
        .clk_fall   (clk_fall),
        .halted     (halted),
        .mode_manual(mode_manual)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty observed=%0d", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] v);
        push(v);
        chk(tag, obs);
    endtask

    task automatic wait_rise(input string tag);
        int n = 0;
        while (clk_out !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        push(1);
        chk(tag, {31'd0, clk_out});
    endtask

    task automatic pulse_width(input string tag);
        int w = 0;
        while (clk_out === 1'b1 && w < 20) begin
            tick();
            w++;
        end
        push(SH);
        chk(tag, w);
    endtask

    initial begin
        logic prev;
        logic e_rise, e_fall;
        int rises, falls, high, first;
        logic prevs;

        reset = 1'b1; clk_cpu_in = 1'b0; btn_step = 1'b0; sw_mode = 1'b0; hlt = 1'b0;
        ticks(3);
        expect_now("rst_clk_out", clk_out, 0);
        expect_now("rst_rise", clk_rise, 0);
        expect_now("rst_fall", clk_fall, 0);
        expect_now("rst_halted", halted, 0);
        expect_now("rst_manual", mode_manual, 0);
        reset = 1'b0;
        tick();
        expect_now("post_rst_manual", mode_manual, 0);

        // Auto run: clk_out follows clk_cpu_in one cycle late, one strobe of each kind per period.
        prev = 1'b0; rises = 0; falls = 0;
        for (int c = 0; c < 80; c++) begin
            clk_cpu_in = ((c / 10) % 2 == 0);
            e_rise = clk_cpu_in & ~prev;
            e_fall = ~clk_cpu_in & prev;
            push(clk_cpu_in); push(e_rise); push(e_fall);
            prev = clk_cpu_in;
            tick();
            chk("auto_out", clk_out);
            chk("auto_rise", clk_rise);
            chk("auto_fall", clk_fall);
            rises += clk_rise;
            falls += clk_fall;
        end
        expect_now("auto_rise_count", rises, 4);
        expect_now("auto_fall_count", falls, 4);

        // Bouncy step press in manual mode.
        sw_mode = 1'b1;
        ticks(10);
        expect_now("man_mode", mode_manual, 1);
        expect_now("man_idle_low", clk_out, 0);
        for (int k = 0; k < 4; k++) begin
            btn_step = (k % 2 == 0);
            tick();
            expect_now("bounce_low", clk_out, 0);
        end
        btn_step = 1'b1;
        rises = 0; high = 0; first = 0; prevs = clk_out;
        for (int j = 1; j <= 30; j++) begin
            if (j == 21) btn_step = 1'b0;
            tick();
            if (clk_out && !prevs) begin
                rises++;
                if (first == 0) first = j;
            end
            high += clk_out;
            prevs = clk_out;
        end
        expect_now("step_pulses", rises, 1);
        expect_now("step_width", high, SH);
        expect_now("step_latency_window", (first >= DB + 2 && first <= DB + 4), 1);

        // Halt asserted during a high phase in auto.
        sw_mode = 1'b0;
        ticks(10);
        expect_now("back_auto", mode_manual, 0);
        clk_cpu_in = 1'b1;
        ticks(3);
        expect_now("auto_high", clk_out, 1);
        hlt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_now("hlt_hold_high", clk_out, 1);
            expect_now("hlt_not_yet", halted, 0);
        end
        clk_cpu_in = 1'b0;
        tick();
        expect_now("hlt_low", clk_out, 0);
        expect_now("hlt_halted", halted, 1);
        for (int k = 0; k < 12; k++) begin
            clk_cpu_in = ((k / 3) % 2 == 0);
            tick();
            expect_now("halt_ignore", clk_out, 0);
            expect_now("halt_stay", halted, 1);
        end

        // Halt release into manual mode.
        clk_cpu_in = 1'b0;
        sw_mode = 1'b1;
        ticks(10);
        expect_now("halt_still", halted, 1);
        hlt = 1'b0;
        tick();
        expect_now("rel_halted", halted, 0);
        expect_now("rel_manual", mode_manual, 1);
        expect_now("rel_low", clk_out, 0);
        for (int k = 0; k < 15; k++) begin
            clk_cpu_in = ((k / 3) % 2 == 0);
            tick();
            expect_now("rel_idle_low", clk_out, 0);
        end
        clk_cpu_in = 1'b0;
        btn_step = 1'b1;
        wait_rise("rel_press_rise");
        pulse_width("rel_press_width");
        btn_step = 1'b0;
        ticks(10);

        // Switch to manual during an auto high phase: waits for the low phase.
        sw_mode = 1'b0;
        ticks(10);
        expect_now("sw_auto", mode_manual, 0);
        clk_cpu_in = 1'b1;
        ticks(2);
        sw_mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            expect_now("sw_wait_high", clk_out, 1);
            expect_now("sw_wait_auto", mode_manual, 0);
        end
        clk_cpu_in = 1'b0;
        tick();
        expect_now("sw_now_low", clk_out, 0);
        expect_now("sw_now_manual", mode_manual, 1);

        // Switch to auto just after a press: the step pulse completes first.
        btn_step = 1'b1;
        ticks(2);
        sw_mode = 1'b0;
        wait_rise("defer_rise");
        expect_now("defer_manual_in_pulse", mode_manual, 1);
        pulse_width("defer_width");
        ticks(2);
        expect_now("defer_auto_after", mode_manual, 0);
        btn_step = 1'b0;
        ticks(10);

        // Reset during the second high cycle of a step pulse.
        sw_mode = 1'b1;
        ticks(10);
        expect_now("r6_manual", mode_manual, 1);
        btn_step = 1'b1;
        wait_rise("r6_rise");
        tick();
        expect_now("r6_second_high", clk_out, 1);
        reset = 1'b1;
        #1;
        expect_now("r6_clk_out", clk_out, 0);
        expect_now("r6_rise", clk_rise, 0);
        expect_now("r6_fall", clk_fall, 0);
        expect_now("r6_halted", halted, 0);
        expect_now("r6_manual0", mode_manual, 0);
        tick();
        expect_now("r6_no_fall", clk_fall, 0);
        reset = 1'b0;
        btn_step = 1'b0;
        tick();
        expect_now("r6_after_manual", mode_manual, 0);
        expect_now("r6_after_out", clk_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
